trig_delay_gen: RTL and testbench
=================================

TRIG_DELAY_GEN -- requirements
Module: trig_delay_gen

Interface
REQ-001 SHALL have parameter DELAY_W, default 12, width of the delay count and delay value.
REQ-002 SHALL have parameter PULSE_W, default 4, width of the pulse length value.
REQ-003 SHALL have parameter HOLDOFF, default 15, number of arm hold-off cycles after ENTrig rises.
REQ-004 SHALL have parameter DELAY_RST, default 100, delay value loaded at reset.
REQ-005 SHALL have parameter PULSE_RST, default 10, pulse length loaded at reset.
REQ-006 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-008 SHALL have port ENTrig  in  1  arm enable; low disarms immediately.
REQ-009 SHALL have port Trigin  in  1  trigger input, already synchronous to CLK.
REQ-010 SHALL have port delay_in  in  DELAY_W  new delay value.
REQ-011 SHALL have port pulse_in  in  PULSE_W  new pulse length.
REQ-012 SHALL have port setdelay  in  1  one-cycle load strobe for delay_in/pulse_in, sampled on CLK, not used as a clock.
REQ-013 SHALL have port Trigout  out  1  registered delayed trigger pulse.
REQ-014 SHALL have port armed  out  1  high in state IDLE only.
REQ-015 SHALL have port busy  out  1  high in states DELAY and PULSE.
REQ-016 SHALL have port trig_cnt  out  8  count of pulses issued, saturating at 255.

Function
REQ-017 SHALL hold delay register D and pulse register P, loaded from delay_in/pulse_in on any cycle with setdelay=1, independent of state.
REQ-018 SHALL apply new D/P only at the next DELAY entry; an in-flight delay or pulse keeps its latched values.
REQ-019 SHALL treat P=0 as pulse length 1.
REQ-020 SHALL detect a trigger as Trigin=1 sampled with Trigin=0 on the previous edge (rising edge); a level held high triggers once.
REQ-021 SHALL implement FSM states DISARMED, HOLDOFF, IDLE, DELAY, PULSE.
REQ-022 SHALL go DISARMED->HOLDOFF when ENTrig=1, counting HOLDOFF cycles, then HOLDOFF->IDLE; HOLDOFF=0 goes straight to IDLE.
REQ-023 SHALL go IDLE->DELAY on a trigger edge, latching D into the delay counter and P into the pulse counter.
REQ-024 SHALL go DELAY->PULSE when the delay counter reaches 0; D=0 enters PULSE on the next edge.
REQ-025 SHALL drive Trigout=1 exactly P cycles, first high cycle after edge k+D+1 where k is the edge sampling the trigger.
REQ-026 SHALL go PULSE->IDLE after the last pulse cycle and increment trig_cnt once per pulse, saturating at 255.
REQ-027 SHALL ignore trigger edges sampled in HOLDOFF, PULSE, or DISARMED, and edges coincident with the PULSE->IDLE transition.
REQ-028 SHALL force DISARMED, Trigout=0 and zero counters on the edge after ENTrig is sampled 0, from any state, aborting any delay or pulse; D, P and trig_cnt are kept.

Reset
REQ-029 SHALL on RST=1 at an edge set state DISARMED, D=DELAY_RST, P=PULSE_RST, trig_cnt=0, Trigout=0, armed=0, busy=0, edge-detect history=1.
REQ-030 SHALL give RST priority over setdelay, ENTrig and Trigin on the same edge.
REQ-031 SHALL, when RST is deasserted with ENTrig=1, need a full HOLDOFF before arming.

Configuration
REQ-032 SHALL honour macro TRIG_DELAY_GEN_RETRIG_EN.
REQ-033 SHALL, with TRIG_DELAY_GEN_RETRIG_EN defined, reload the delay counter with current D on a trigger edge sampled in DELAY, extending the delay.
REQ-034 SHALL, without TRIG_DELAY_GEN_RETRIG_EN, ignore trigger edges sampled in DELAY.

Verification
REQ-035 SHALL cover: reset, ENTrig=1, wait 16 cycles, Trigin edge -> Trigout high for 10 cycles starting 101 edges after the trigger edge; trig_cnt=1.
REQ-036 SHALL cover: setdelay with delay_in=0, pulse_in=0 -> trigger gives a 1-cycle Trigout one edge after the trigger edge.
REQ-037 SHALL cover: D=20, second Trigin edge 5 cycles after the first -> pulse at +21 without macro, at +26 with macro.
REQ-038 SHALL cover: ENTrig dropped mid-PULSE -> Trigout 0 next edge; re-arm needs 15 hold-off cycles; trigger in hold-off gives no pulse.
REQ-039 SHALL cover: setdelay delay_in=50 during DELAY with D=100 -> current pulse at +101, next trigger pulse at +51.
REQ-040 SHALL cover: 300 triggers -> trig_cnt saturates at 255; Trigin held high 500 cycles gives one pulse only.

Source files
------------

// File: rtl/trig_delay_gen.sv
//------------------------------------------------------------------------------
// Module   : trig_delay_gen
// Purpose  : Armed trigger delay/pulse generator with hold-off and pulse count.
//            Optional retrigger in DELAY: define TRIG_DELAY_GEN_RETRIG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trig_delay_gen #(
  parameter int DELAY_W   = 12,
  parameter int PULSE_W   = 4,
  parameter int HOLDOFF   = 15,
  parameter int DELAY_RST = 100,
  parameter int PULSE_RST = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENTrig,
  input  logic               Trigin,
  input  logic [DELAY_W-1:0] delay_in,
  input  logic [PULSE_W-1:0] pulse_in,
  input  logic               setdelay,
  output logic               Trigout,
  output logic               armed,
  output logic               busy,
  output logic [7:0]         trig_cnt
);

  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0]      c_HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [PULSE_W-1:0] c_PONE      = PULSE_W'(1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_HOLDOFF  = 3'd1,
    S_IDLE     = 3'd2,
    S_DELAY    = 3'd3,
    S_PULSE    = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_dly, r_dcnt, w_dcnt_nxt;
  logic [PULSE_W-1:0] r_pls, r_pcnt, w_pcnt_nxt;
  logic [HW-1:0]      r_hcnt, w_hcnt_nxt;
  logic [7:0]         r_trig_cnt;
  logic               r_trig_d, r_trigout, w_trigout_nxt, w_done;
  logic               w_edge, w_retrig;

  assign w_edge = Trigin & ~r_trig_d;

`ifdef TRIG_DELAY_GEN_RETRIG_EN
  assign w_retrig = w_edge;
`else
  assign w_retrig = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_pcnt_nxt    = r_pcnt;
    w_hcnt_nxt    = r_hcnt;
    w_trigout_nxt = 1'b0;
    w_done        = 1'b0;
    if (!ENTrig) begin
      // Disarm aborts everything; D, P and the pulse count survive.
      w_state_nxt = S_DISARMED;
      w_dcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
      w_hcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (HOLDOFF == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLDOFF;
            w_hcnt_nxt  = c_HOLD_LAST;
          end
        end
        S_HOLDOFF: begin
          if (r_hcnt == '0) w_state_nxt = S_IDLE;
          else              w_hcnt_nxt  = r_hcnt - 1'b1;
        end
        S_IDLE: begin
          if (w_edge) begin
            w_state_nxt = S_DELAY;
            w_dcnt_nxt  = r_dly;
            w_pcnt_nxt  = (r_pls == '0) ? c_PONE : r_pls;
          end
        end
        S_DELAY: begin
          if (w_retrig) begin
            w_dcnt_nxt = r_dly;
          end else if (r_dcnt == '0) begin
            w_state_nxt   = S_PULSE;
            w_trigout_nxt = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (r_pcnt <= c_PONE) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_pcnt_nxt    = r_pcnt - 1'b1;
            w_trigout_nxt = 1'b1;
          end
        end
        default: w_state_nxt = S_DISARMED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_DISARMED;
      r_dly      <= DELAY_W'(DELAY_RST);
      r_pls      <= PULSE_W'(PULSE_RST);
      r_dcnt     <= '0;
      r_pcnt     <= '0;
      r_hcnt     <= '0;
      r_trig_cnt <= '0;
      r_trigout  <= 1'b0;
      r_trig_d   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_trigout <= w_trigout_nxt;
      r_trig_d  <= Trigin;
      if (setdelay) begin
        r_dly <= delay_in;
        r_pls <= pulse_in;
      end
      if (w_done && (r_trig_cnt != 8'hFF)) r_trig_cnt <= r_trig_cnt + 8'd1;
    end
  end

  assign Trigout  = r_trigout;
  assign armed    = (r_state == S_IDLE);
  assign busy     = (r_state == S_DELAY) || (r_state == S_PULSE);
  assign trig_cnt = r_trig_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trig_delay_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_trig_delay_gen
// Purpose  : Scoreboard bench for trig_delay_gen; pulses checked by a monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trig_delay_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENTrig = 1'b1;
  logic        Trigin = 1'b0;
  logic [11:0] delay_in = '0;
  logic [3:0]  pulse_in = '0;
  logic        setdelay = 1'b0;
  logic        Trigout, armed, busy;
  logic [7:0]  trig_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int q_start[$];
  int q_len[$];

  trig_delay_gen dut (
    .CLK(CLK), .RST(RST), .ENTrig(ENTrig), .Trigin(Trigin),
    .delay_in(delay_in), .pulse_in(pulse_in), .setdelay(setdelay),
    .Trigout(Trigout), .armed(armed), .busy(busy), .trig_cnt(trig_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each completed Trigout pulse is matched against the queue head.
  bit mon_prev  = 1'b0;
  int mon_start = 0;
  always @(negedge CLK) begin
    if (Trigout && !mon_prev) mon_start = cyc;
    if (!Trigout && mon_prev) begin
      if (q_start.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got start %0d len %0d expected none",
                 mon_start, cyc - mon_start);
      end else begin
        chk("pulse_start", mon_start, q_start.pop_front());
        chk("pulse_len", cyc - mon_start, q_len.pop_front());
      end
    end
    mon_prev = Trigout;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_pulse(input int start, input int len);
    q_start.push_back(start);
    q_len.push_back(len);
  endtask

  task automatic trig(output int k);
    Trigin = 1'b1;
    k = cyc + 1;
    tick(1);
    Trigin = 1'b0;
  endtask

  task automatic setd(input int d, input int p);
    setdelay = 1'b1;
    delay_in = 12'(d);
    pulse_in = 4'(p);
    tick(1);
    setdelay = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (q_start.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (q_start.size() != 0) chk({name, "_timeout"}, q_start.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, c;
    tick(2);
    chk("rst_trigout", Trigout, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", trig_cnt, 0);
    RST = 1'b0;
    tick(15);
    chk("holdoff_armed", armed, 0);
    tick(1);
    chk("arm_after_holdoff", armed, 1);

    // Default D=100, P=10
    trig(k);
    expect_pulse(k + 101, 10);
    chk("delay_busy", busy, 1);
    chk("delay_armed", armed, 0);
    wait_done("dflt");
    chk("cnt_1", trig_cnt, 1);

    // D=0, P=0 -> one-cycle pulse one edge later
    setd(0, 0);
    trig(k);
    expect_pulse(k + 1, 1);
    wait_done("zero");
    chk("cnt_2", trig_cnt, 2);

    // Second edge during DELAY
    setd(20, 3);
    trig(k);
    tick(4);
    trig(k2);
`ifdef TRIG_DELAY_GEN_RETRIG_EN
    expect_pulse(k + 26, 3);
`else
    expect_pulse(k + 21, 3);
`endif
    wait_done("retrig");
    chk("cnt_3", trig_cnt, 3);

    // New D/P during DELAY only affects the next trigger
    setd(100, 2);
    trig(k);
    expect_pulse(k + 101, 2);
    tick(10);
    setd(50, 4);
    wait_done("inflight");
    trig(k2);
    expect_pulse(k2 + 51, 4);
    wait_done("newd");
    chk("cnt_5", trig_cnt, 5);

    // Disarm in the middle of a pulse
    setd(5, 10);
    trig(k);
    expect_pulse(k + 6, 3);
    tick(8);
    ENTrig = 1'b0;
    tick(1);
    chk("abort_trigout", Trigout, 0);
    chk("abort_armed", armed, 0);
    chk("abort_busy", busy, 0);
    tick(2);
    chk("abort_cnt_kept", trig_cnt, 5);
    wait_done("abort");

    // Re-arm: trigger inside hold-off is ignored
    ENTrig = 1'b1;
    c = cyc;
    tick(5);
    trig(k);
    tick(c + 15 - cyc);
    chk("rearm_holdoff", armed, 0);
    tick(1);
    chk("rearm_armed", armed, 1);
    tick(60);
    chk("holdoff_trig_ignored", trig_cnt, 5);

    // Level held high triggers once
    Trigin = 1'b1;
    k = cyc + 1;
    expect_pulse(k + 6, 10);
    tick(500);
    Trigin = 1'b0;
    tick(2);
    wait_done("level");
    chk("level_once", trig_cnt, 6);

    // Saturation of the pulse counter
    setd(0, 0);
    for (int i = 0; i < 300; i++) begin
      trig(k);
      expect_pulse(k + 1, 1);
      tick(2);
    end
    wait_done("sat");
    chk("cnt_sat", trig_cnt, 255);
    chk("sat_armed", armed, 1);

    // Reset wins over setdelay and Trigin; D/P return to reset values
    RST = 1'b1;
    setdelay = 1'b1;
    delay_in = 12'd7;
    pulse_in = 4'd2;
    Trigin = 1'b1;
    tick(1);
    RST = 1'b0;
    setdelay = 1'b0;
    chk("rst2_cnt", trig_cnt, 0);
    chk("rst2_armed", armed, 0);
    tick(20);
    chk("rst2_armed_late", armed, 1);
    Trigin = 1'b0;
    tick(1);
    trig(k);
    expect_pulse(k + 101, 10);
    wait_done("rst2");
    chk("rst2_cnt_1", trig_cnt, 1);

    tick(5);
    chk("queue_empty", q_start.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
